wb_commit_ctrl: RTL and testbench

Writeback-side controller that drives the register file write port (wen/rd/wdata) and owns its pending-write scoreboard. Merges single-cycle ALU results with out-of-order-in-time long-latency results (load/mul-div), buffered in a small FIFO. Answers decode busy queries so dependent instructions stall until their source register has been written. Sits between EX/MEM result paths and the register file write port; write-port outputs are combinational so the register file's internal write bypass stays effective.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/wb_commit_ctrl_if.sv | 36 +++
 rtl/wb_fifo.sv | 50 +++++
 rtl/wb_commit_ctrl.sv | 80 ++++++++
 tb/tb_wb_commit_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and the writeback entry type.
// Every block on the writeback path imports this package.
package cpu_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = $clog2(NREG);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t        rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_commit_ctrl_if.sv
// Result, issue, decode-query and register-file write-port signals of the writeback controller.
// The master modport is the pipeline side; the slave modport is the controller.
interface wb_commit_ctrl_if;
  import cpu_pkg::*;

  logic            pipeline_en;
  logic            alu_valid;
  reg_idx_t        alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  reg_idx_t        lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            iss_valid;
  reg_idx_t        iss_rd;
  reg_idx_t        rs1;
  reg_idx_t        rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            wen;
  reg_idx_t        rd;
  logic [XLEN-1:0] wdata;
  logic            waw_err;

  modport master (
    output pipeline_en, alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data, iss_valid, iss_rd, rs1, rs2,
    input  lsu_ready, rs1_busy, rs2_busy, wen, rd, wdata, waw_err
  );

  modport slave (
    input  pipeline_en, alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data, iss_valid, iss_rd, rs1, rs2,
    output lsu_ready, rs1_busy, rs2_busy, wen, rd, wdata, waw_err
  );
endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries.
// Ready depends only on fullness, so there is no combinational path from pop to push_ready.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_valid,
  output logic      push_ready,
  input  wb_entry_t push_data,
  input  logic      pop,
  output logic      empty,
  output wb_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_entry_t   mem [DEPTH];
  logic        full;
  logic        do_push;
  logic        do_pop;

  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign push_ready = !full;
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && !empty;
  assign head       = mem[rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; only the pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/wb_commit_ctrl.sv
// Writeback controller: arbitrates ALU vs buffered long-latency results onto the register
// file write port and tracks pending long-latency destinations for decode stalls.
module wb_commit_ctrl
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_commit_ctrl_if.slave   bus
);

  wb_entry_t       push_entry;
  wb_entry_t       head;
  logic            fifo_empty;
  logic            alu_hit;
  logic            pop;
  logic            head_writes;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic            waw_err_q;

  assign push_entry = '{rd: bus.lsu_rd, data: bus.lsu_data};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (bus.lsu_valid),
    .push_ready (bus.lsu_ready),
    .push_data  (push_entry),
    .pop        (pop),
    .empty      (fifo_empty),
    .head       (head)
  );

  assign alu_hit     = bus.alu_valid && (bus.alu_rd != '0);
  assign pop         = bus.pipeline_en && !alu_hit && !fifo_empty;
  assign head_writes = (head.rd != '0);

  // Write port stays combinational so the register file's write bypass sees it this cycle.
  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    bus.wen   = 1'b0;
    bus.rd    = '0;
    bus.wdata = '0;
    if (alu_hit) begin
      bus.wen   = 1'b1;
      bus.rd    = bus.alu_rd;
      bus.wdata = bus.alu_data;
    end else if (!fifo_empty) begin
      bus.wen   = head_writes;
      bus.rd    = head.rd;
      bus.wdata = head.data;
    end
  end

  // Clear on commit first, then set, so a same-cycle issue to that register wins.
  always_comb begin
    pending_nxt = pending;
    if (pop && head_writes) pending_nxt[head.rd] = 1'b0;
    if (bus.iss_valid && bus.pipeline_en && (bus.iss_rd != '0)) pending_nxt[bus.iss_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      waw_err_q <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (bus.pipeline_en && alu_hit && pending[bus.alu_rd]) waw_err_q <= 1'b1;
    end
  end

  assign bus.waw_err  = waw_err_q;
  // A source committing this cycle is forwarded by the register file, so it is not busy.
  assign bus.rs1_busy = (bus.rs1 != '0) && pending[bus.rs1] && !(pop && (head.rd == bus.rs1));
  assign bus.rs2_busy = (bus.rs2 != '0) && pending[bus.rs2] && !(pop && (head.rd == bus.rs2));

endmodule

// File: tb/tb_wb_commit_ctrl.sv
// Self-checking bench for wb_commit_ctrl: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the writeback rules.
module tb_wb_commit_ctrl;
  import cpu_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  wb_commit_ctrl_if bus ();

  wb_commit_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  wb_entry_t       q[$];
  bit [NREG-1:0]   m_pend;
  bit              m_waw;

  // Expected values for the current input pattern
  bit              e_ready, e_hit, e_pop, e_wen, e_b1, e_b2;
  logic [4:0]      e_rd;
  logic [31:0]     e_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_eval();
    e_ready = (q.size() < DEPTH);
    e_hit   = bus.alu_valid && (bus.alu_rd != 0);
    e_pop   = bus.pipeline_en && !e_hit && (q.size() > 0);
    e_wen = 0; e_rd = 0; e_wdata = 0;
    if (e_hit) begin
      e_wen = 1; e_rd = bus.alu_rd; e_wdata = bus.alu_data;
    end else if (q.size() > 0) begin
      e_wen = (q[0].rd != 0); e_rd = q[0].rd; e_wdata = q[0].data;
    end
    e_b1 = (bus.rs1 != 0) && m_pend[bus.rs1] && !(e_pop && q[0].rd == bus.rs1);
    e_b2 = (bus.rs2 != 0) && m_pend[bus.rs2] && !(e_pop && q[0].rd == bus.rs2);
  endfunction

  task automatic clear_inputs();
    bus.pipeline_en = 1; bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    bus.iss_valid = 0; bus.iss_rd = 0; bus.rs1 = 0; bus.rs2 = 0;
  endtask

  // Let inputs settle, then compare every output with the model.
  task automatic settle();
    #1;
    model_eval();
    check("wen", bus.wen, e_wen);
    check("rd", bus.rd, e_rd);
    check("wdata", bus.wdata, e_wdata);
    check("lsu_ready", bus.lsu_ready, e_ready);
    check("rs1_busy", bus.rs1_busy, e_b1);
    check("rs2_busy", bus.rs2_busy, e_b2);
    check("waw_err", bus.waw_err, m_waw);
  endtask

  // Advance the model by one cycle using the current inputs, then cross the clock edge.
  task automatic tick();
    wb_entry_t h;
    bit        do_push;
    model_eval();
    do_push = bus.lsu_valid && e_ready;
    if (bus.pipeline_en && e_hit && m_pend[bus.alu_rd]) m_waw = 1;
    if (e_pop) begin
      h = q.pop_front();
      if (h.rd != 0) m_pend[h.rd] = 0;
    end
    if (bus.iss_valid && bus.pipeline_en && bus.iss_rd != 0) m_pend[bus.iss_rd] = 1;
    if (do_push) q.push_back('{rd: bus.lsu_rd, data: bus.lsu_data});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    q.delete(); m_pend = '0; m_waw = 0;
    #1;
    check("rst_wen", bus.wen, 1'b0);
    check("rst_rd", bus.rd, 5'd0);
    check("rst_wdata", bus.wdata, 32'd0);
    check("rst_ready", bus.lsu_ready, 1'b1);
    check("rst_waw", bus.waw_err, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1;
    #1;
  endtask

  initial begin
    clear_inputs();
    q.delete(); m_pend = '0; m_waw = 0;
    do_reset();

    // Idle: no source is ever busy after reset
    for (int r = 0; r < NREG; r++) begin
      bus.rs1 = 5'(r);
      #1;
      check("idle_rs1_busy", bus.rs1_busy, 1'b0);
    end
    clear_inputs(); settle(); tick();

    // ALU write appears on the port in the same cycle; x0 is ignored
    bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF; settle();
    check("alu_wen", bus.wen, 1'b1);
    check("alu_rd", bus.rd, 5'd5);
    check("alu_wdata", bus.wdata, 32'hDEADBEEF);
    tick();
    bus.alu_rd = 0; settle();
    check("alu_x0_wen", bus.wen, 1'b0);
    tick();

    // Issue x7, result returns through the FIFO, busy clears on the commit cycle
    clear_inputs(); bus.iss_valid = 1; bus.iss_rd = 7; settle(); tick();
    clear_inputs(); bus.rs1 = 7; bus.lsu_valid = 1; bus.lsu_rd = 7; bus.lsu_data = 32'h1234; settle();
    check("iss_busy", bus.rs1_busy, 1'b1);
    tick();
    clear_inputs(); bus.rs1 = 7; settle();
    check("lsu_wen", bus.wen, 1'b1);
    check("lsu_rd", bus.rd, 5'd7);
    check("lsu_wdata", bus.wdata, 32'h1234);
    check("commit_busy", bus.rs1_busy, 1'b0);
    tick();
    settle();
    check("after_busy", bus.rs1_busy, 1'b0);
    tick();

    // ALU holds the port while the FIFO fills; drains in order once ALU goes quiet
    clear_inputs(); bus.alu_valid = 1; bus.alu_rd = 1;
    bus.lsu_valid = 1; bus.lsu_rd = 3; bus.lsu_data = 32'h33; settle(); tick();
    bus.lsu_rd = 4; bus.lsu_data = 32'h44; settle();
    check("fill_ready", bus.lsu_ready, 1'b1);
    tick();
    bus.lsu_rd = 8; bus.lsu_data = 32'h88; settle();
    check("full_ready", bus.lsu_ready, 1'b0);
    tick();
    clear_inputs(); settle();
    check("drain0_rd", bus.rd, 5'd3);
    check("drain0_wen", bus.wen, 1'b1);
    tick();
    settle();
    check("drain1_rd", bus.rd, 5'd4);
    check("drain1_ready", bus.lsu_ready, 1'b1);
    tick();
    settle();
    check("drained_wen", bus.wen, 1'b0);
    tick();

    // Stalled head is held stable until pipeline_en returns
    clear_inputs(); bus.iss_valid = 1; bus.iss_rd = 9;
    bus.lsu_valid = 1; bus.lsu_rd = 9; bus.lsu_data = 32'h99; settle(); tick();
    for (int i = 0; i < 3; i++) begin
      clear_inputs(); bus.pipeline_en = 0; bus.rs1 = 9; settle();
      check("hold_wen", bus.wen, 1'b1);
      check("hold_rd", bus.rd, 5'd9);
      check("hold_wdata", bus.wdata, 32'h99);
      check("hold_busy", bus.rs1_busy, 1'b1);
      tick();
    end
    clear_inputs(); bus.rs1 = 9; settle();
    check("release_busy", bus.rs1_busy, 1'b0);
    tick();
    settle();
    check("cleared_busy", bus.rs1_busy, 1'b0);
    tick();

    // WAW hazard is sticky until reset; reset mid-drain flushes everything
    clear_inputs(); bus.iss_valid = 1; bus.iss_rd = 6; settle(); tick();
    clear_inputs(); bus.alu_valid = 1; bus.alu_rd = 6; bus.alu_data = 32'h66;
    bus.lsu_valid = 1; bus.lsu_rd = 10; bus.lsu_data = 32'hA; settle(); tick();
    check("waw_set", bus.waw_err, 1'b1);
    clear_inputs(); bus.lsu_valid = 1; bus.lsu_rd = 11; bus.lsu_data = 32'hB; settle(); tick();
    clear_inputs(); settle();
    check("waw_sticky", bus.waw_err, 1'b1);
    tick();
    do_reset();
    settle();
    check("flush_wen", bus.wen, 1'b0);
    tick();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      bus.pipeline_en = ($urandom_range(0, 3) != 0);
      bus.alu_valid   = ($urandom_range(0, 9) < 4);
      bus.alu_rd      = 5'($urandom_range(0, 7));
      bus.alu_data    = $urandom;
      bus.lsu_valid   = ($urandom_range(0, 1) != 0);
      bus.lsu_rd      = 5'($urandom_range(0, 7));
      bus.lsu_data    = $urandom;
      bus.iss_valid   = ($urandom_range(0, 9) < 3);
      bus.iss_rd      = 5'($urandom_range(0, 7));
      bus.rs1         = 5'($urandom_range(0, 7));
      bus.rs2         = 5'($urandom_range(0, 7));
      settle();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
